// File: rtl/stack_pkg.sv
// Shared types and constants for the stack port: FSM states, op encodings, empty pointer.
package stack_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPushWr,
        StPopRd,
        StResp,
        StErr
    } stack_state_e;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam logic [15:0] SP_EMPTY = 16'hFFFF;

endpackage

// File: rtl/stack_bounds_chk.sv
// Combinational overflow/underflow check for an empty-descending stack.
module stack_bounds_chk
    import stack_pkg::*;
#(
    parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
    input  logic [15:0] sp,
    input  logic        op,
    output logic        overflow,
    output logic        underflow
);

    assign overflow  = (op == OP_PUSH) && (sp < STACK_LIMIT);
    assign underflow = (op == OP_POP) && (sp == SP_EMPTY);

endmodule

// File: rtl/stack_port.sv
// Push/pop request port driving a memory bus and an external stack pointer,
// with bounds checking and an ack timeout.
module stack_port
    import stack_pkg::*;
#(
    parameter logic [15:0] STACK_LIMIT = 16'hFF00,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_op,
    input  logic [15:0] req_data,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic        resp_err,
    input  logic [15:0] sp,
    output logic        sp_push,
    output logic        sp_pop,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

    stack_state_e    r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [15:0]     r_addr, r_wdata, r_resp_data;
    logic            r_rdy, r_resp_valid, r_resp_err;
    logic            w_accept, w_overflow, w_underflow, w_in_mem, w_ack;

    stack_bounds_chk #(
        .STACK_LIMIT (STACK_LIMIT)
    ) u_bounds (
        .sp        (sp),
        .op        (req_op),
        .overflow  (w_overflow),
        .underflow (w_underflow)
    );

    // r_rdy holds off acceptance until the first edge after reset release;
    // the pending response register covers the cycle after ERR.
    assign req_ready = (r_state == StIdle) && r_rdy && !r_resp_valid;
    assign w_accept  = req_valid && req_ready;
    assign w_in_mem  = (r_state == StPushWr) || (r_state == StPopRd);
    assign w_ack     = w_in_mem && mem_ack;

    assign mem_we    = (r_state == StPushWr);
    assign mem_re    = (r_state == StPopRd);
    assign sp_push   = mem_we && mem_ack;
    assign sp_pop    = mem_re && mem_ack;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_data  = r_resp_data;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_cnt_d = '0;
                    if (w_overflow || w_underflow) begin
                        w_state_d = StErr;
                    end else if (req_op == OP_POP) begin
                        w_state_d = StPopRd;
                    end else begin
                        w_state_d = StPushWr;
                    end
                end
            end
            StPushWr, StPopRd: begin
                if (mem_ack) begin
                    w_state_d = StResp;
                    w_cnt_d   = '0;
                end else if (r_cnt == CntLast) begin
                    w_state_d = StErr;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StResp, StErr: w_state_d = StIdle;
            default:       w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_rdy   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= (req_op == OP_POP) ? 16'(sp + 16'd1) : sp;
            r_wdata <= req_data;
        end
    end

    // Response is registered so success and error both surface two cycles after accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= w_ack || (r_state == StErr);
            r_resp_err   <= (r_state == StErr);
            r_resp_data  <= (r_state == StPopRd && mem_ack) ? mem_rdata : '0;
        end
    end

endmodule
